// File: rtl/ask_pkg.sv
// ASK sequencer shared definitions.
//   SYM_W       : baseband symbol width (signed, -4..+3)
//   CW_W, MOD_W : carrier word and multiplier product widths used by the
//                 downstream ASK multiplier this sequencer paces
//   seq_state_t : sequencer FSM states
package ask_pkg;
  localparam int SYM_W = 3;
  localparam int CW_W  = 10;
  localparam int MOD_W = CW_W + SYM_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;
endpackage

// File: rtl/sym_fifo.sv
// Synchronous symbol FIFO with show-ahead output.
//   clk, rst    : clock, async active-high reset (flushes pointers/count)
//   push, pop   : write/read strobes; caller guarantees no push when full
//                 and no pop when empty
//   din / dout  : write data / current head (valid while !empty)
//   full, empty : occupancy flags from the registered count
module sym_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: it is only read when the count says it is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == DEPTH[AW:0]);
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/ask_symbol_sequencer.sv
// ASK modulator sequencer: buffers symbols, holds each on base_sig for SPS
// carrier samples of CLK_DIV clocks, and steps the carrier LUT address.
//   clk, rst      : clock, async active-high reset
//   enable        : run request
//   sym_valid/_data/_ready : upstream symbol handshake
//   base_sig      : symbol to the ASK multiplier
//   carrier_addr  : carrier LUT address, phase-continuous within a burst
//   sample_stb    : pulse when the datapath sample advances
//   sym_start     : pulse when a new symbol lands on base_sig
//   busy          : sequencer not idle
//   underrun      : pulse when a symbol boundary finds the buffer empty
module ask_symbol_sequencer
  import ask_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SPS        = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 6,
  parameter int PHASE_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym_data,
  output logic              sym_ready,
  output logic [SYM_W-1:0]  base_sig,
  output logic [ADDR_W-1:0] carrier_addr,
  output logic              sample_stb,
  output logic              sym_start,
  output logic              busy,
  output logic              underrun
);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int SAMP_W = $clog2(SPS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SPS - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PHASE_STEP);

  seq_state_t        state_q;
  logic [DIV_W-1:0]  div_q;
  logic [SAMP_W-1:0] samp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SYM_W-1:0]  base_q;
  logic              stb_q, start_q, under_q, rdy_en_q;

  logic              full, empty, push, pop, boundary;
  logic [SYM_W-1:0]  head;

  // rdy_en_q keeps sym_ready low while reset is held and until the first
  // clock after release.
  assign sym_ready = rdy_en_q & ~full;
  assign push      = sym_valid & sym_ready;
  assign boundary  = (div_q == DIV_LAST) && (samp_q == SAMP_LAST);
  // Only IDLE entry and a seamless RUN boundary consume a symbol.
  assign pop       = enable & ~empty &
                     ((state_q == IDLE) | ((state_q == RUN) & boundary));

  sym_fifo #(.W(SYM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sym_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      samp_q   <= '0;
      addr_q   <= '0;
      base_q   <= '0;
      stb_q    <= 1'b0;
      start_q  <= 1'b0;
      under_q  <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      stb_q    <= 1'b0;
      start_q  <= 1'b0;
      under_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= RUN;
            base_q  <= head;
            start_q <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            stb_q <= 1'b1;
            if (samp_q == SAMP_LAST) begin
              samp_q <= '0;
              if (pop) begin
                base_q  <= head;
                start_q <= 1'b1;
                addr_q  <= addr_q + STEP;
              end else begin
                // Burst ends: phase restarts at 0 for the next burst.
                state_q <= IDLE;
                base_q  <= '0;
                addr_q  <= '0;
                under_q <= (state_q == RUN) && enable;
              end
            end else begin
              samp_q <= samp_q + 1'b1;
              addr_q <= addr_q + STEP;
              if (state_q == RUN && !enable) state_q <= DRAIN;
            end
          end else begin
            div_q <= div_q + 1'b1;
            if (state_q == RUN && !enable) state_q <= DRAIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign base_sig     = base_q;
  assign carrier_addr = addr_q;
  assign sample_stb   = stb_q;
  assign sym_start    = start_q;
  assign underrun     = under_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ask_symbol_sequencer.sv
// Scoreboarded bench for ask_symbol_sequencer. Accepted symbols are queued as
// expected base_sig values; a negedge monitor pops them on sym_start and checks
// every output against symbol-level timing rules (64-clk symbols, strobe every
// 4 clks, phase advancing by 4 per strobe, burst end/underrun/drain rules).
module tb_ask_symbol_sequencer;
  localparam int CLK_DIV  = 4;
  localparam int SPS      = 16;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 6;
  localparam int STEP     = 4;
  localparam int SYM_CLKS = CLK_DIV * SPS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              sym_valid = 1'b0;
  logic [2:0]        sym_data = 3'b000;
  logic              sym_ready, sample_stb, sym_start, busy, underrun;
  logic [2:0]        base_sig;
  logic [ADDR_W-1:0] carrier_addr;

  int checks = 0;
  int errors = 0;
  logic [2:0] mq[$];

  ask_symbol_sequencer #(
    .CLK_DIV(CLK_DIV), .SPS(SPS), .FIFO_DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .PHASE_STEP(STEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sym_valid    (sym_valid),
    .sym_data     (sym_data),
    .sym_ready    (sym_ready),
    .base_sig     (base_sig),
    .carrier_addr (carrier_addr),
    .sample_stb   (sample_stb),
    .sym_start    (sym_start),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model / monitor.
  initial begin : mon
    bit         in_burst, dropped, en_last, rst_prev, pushed_last;
    bit         e_stb, e_start, e_und;
    int         age, nstb, avail, e_base, e_addr;
    logic [2:0] cur;
    in_burst = 0; dropped = 0; en_last = 0; rst_prev = 1; pushed_last = 0;
    age = 0; nstb = 0; cur = 3'b000;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst busy", int'(busy), 0);
        chk("rst base_sig", int'(base_sig), 0);
        chk("rst carrier_addr", int'(carrier_addr), 0);
        chk("rst strobes", int'({sample_stb, sym_start, underrun}), 0);
        chk("rst sym_ready", int'(sym_ready), 0);
        mq.delete();
        in_burst = 0; pushed_last = 0; rst_prev = 1; en_last = enable;
        continue;
      end
      // Buffer occupancy seen by the FSM at the edge just taken.
      avail = mq.size() - int'(pushed_last);
      e_stb = 0; e_start = 0; e_und = 0;
      if (in_burst) begin
        age++;
        if (age % CLK_DIV == 0) begin
          e_stb = 1;
          nstb++;
        end
        if (age == SYM_CLKS) begin
          if (!dropped && en_last && avail > 0) begin
            e_start = 1; cur = mq.pop_front(); age = 0; dropped = 0;
          end else begin
            e_und = !dropped && en_last;
            in_burst = 0;
          end
        end else if (!en_last) begin
          dropped = 1;
        end
      end else if (en_last && avail > 0) begin
        e_start = 1; cur = mq.pop_front();
        in_burst = 1; age = 0; nstb = 0; dropped = 0;
      end
      e_base = in_burst ? int'(cur) : 0;
      e_addr = in_burst ? (nstb * STEP) % (1 << ADDR_W) : 0;
      chk("sample_stb", int'(sample_stb), int'(e_stb));
      chk("sym_start", int'(sym_start), int'(e_start));
      chk("underrun", int'(underrun), int'(e_und));
      chk("busy", int'(busy), int'(in_burst));
      chk("base_sig", int'(base_sig), e_base);
      chk("carrier_addr", int'(carrier_addr), e_addr);
      chk("sym_ready", int'(sym_ready), int'(!rst_prev && mq.size() < DEPTH));
      pushed_last = sym_valid && sym_ready;
      if (pushed_last) mq.push_back(sym_data);
      en_last = enable;
      rst_prev = 0;
    end
  end

  task automatic push(input logic [2:0] d);
    bit acc;
    int n;
    acc = 0; n = 0;
    sym_valid = 1'b1;
    sym_data  = d;
    do begin
      @(negedge clk);
      acc = sym_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 2000);
    if (!acc) chk("push timeout", 0, 1);
    sym_valid = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : drv
    bit seen;
    #1 rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);

    // Single symbol from idle, then underrun.
    enable = 1'b1;
    push(3'b011);
    wait_clks(SYM_CLKS + 16);

    // Three back-to-back symbols.
    push(3'b001); push(3'b110); push(3'b011);
    wait_clks(3 * SYM_CLKS + 20);

    // Fill while disabled; fifth held off until the first pop.
    enable = 1'b0;
    push(3'b100); push(3'b010); push(3'b111); push(3'b101);
    sym_valid = 1'b1; sym_data = 3'b001;
    wait_clks(10);
    enable = 1'b1;
    push(3'b001);
    wait_clks(5 * SYM_CLKS + 20);

    // Long burst: phase wraps repeatedly.
    for (int i = 0; i < 20; i++) push(3'($urandom));
    wait_clks(5 * SYM_CLKS + 20);

    // Enable dropped mid-symbol.
    enable = 1'b0;
    push(3'b010); push(3'b101);
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = sym_start;
    end
    if (!seen) chk("drain start timeout", 0, 1);
    wait_clks(19);
    enable = 1'b0;
    wait_clks(SYM_CLKS + 16);
    enable = 1'b1;
    wait_clks(2 * SYM_CLKS + 16);

    // Reset mid-symbol with three queued.
    push(3'b100); push(3'b011); push(3'b110); push(3'b001);
    wait_clks(30);
    rst = 1'b1;
    #1;
    chk("async busy", int'(busy), 0);
    chk("async base_sig", int'(base_sig), 0);
    chk("async sym_ready", int'(sym_ready), 0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(40);

    // Random traffic with occasional enable toggles.
    for (int i = 0; i < 3000; i++) begin
      sym_valid = ($urandom_range(0, 2) == 0);
      sym_data  = 3'($urandom);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      wait_clks(1);
    end
    sym_valid = 1'b0;
    enable = 1'b0;
    wait_clks(SYM_CLKS + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
